// File: rtl/bch_decoder_param.sv
// bch_decoder_param: binary BCH decoder back-end over GF(2^M).
// Solves the error locator with inversionless Berlekamp-Massey, then finds
// error positions with a serial Chien search; T locations per codeword.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid            syndrome strobe (S1 first, S2T last)
//   in_syndrome [M]     syndrome in exponent form, all-ones = zero element
//   in_ready            high in IDLE/LOAD only
//   out_valid           location strobe, T cycles per frame
//   out_location [M]    error bit position, all-ones = no entry
//   out_fail            decoding failure flag, valid with out_valid
// Build option: define BCH_FAIL_DETECT_EN to build the root counter and
// failure check; otherwise out_fail is tied low.
module bch_decoder_param #(
    parameter int         M         = 4,
    parameter int         T         = 3,
    parameter logic [M:0] PRIM_POLY = 5'b10011
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [M-1:0] in_syndrome,
    output logic         in_ready,
    output logic         out_valid,
    output logic [M-1:0] out_location,
    output logic         out_fail
);
    localparam int N    = (1 << M) - 1;
    localparam int LW   = $clog2(T + 1) + 1;
    localparam int PW   = $clog2(T + 1);
    localparam int CMAX = (N > 2 * T) ? N : 2 * T;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [M-1:0] ONES = '1;

    // Tables are shifted in from the top so entry 0 ends at the bottom.
    function automatic logic [(N+1)*M-1:0] build_exp();
        logic [(N+1)*M-1:0] tab;
        logic [M:0]         v;
        tab = '0;
        v   = (M+1)'(1);
        for (int k = 0; k <= N; k++) begin
            tab = {v[M-1:0], tab[(N+1)*M-1:M]};
            v   = v << 1;
            if (v[M]) v = v ^ PRIM_POLY;
        end
        return tab;
    endfunction

    function automatic logic [(N+1)*M-1:0] build_log();
        logic [(N+1)*M-1:0] tab;
        logic [M:0]         v;
        logic [M-1:0]       res;
        tab = '0;
        for (int a = 0; a <= N; a++) begin
            res = ONES;
            v   = (M+1)'(1);
            for (int k = 0; k < N; k++) begin
                if (v[M-1:0] == M'(a)) res = M'(k);
                v = v << 1;
                if (v[M]) v = v ^ PRIM_POLY;
            end
            tab = {res, tab[(N+1)*M-1:M]};
        end
        return tab;
    endfunction

    localparam logic [(N+1)*M-1:0] EXP_PK = build_exp();
    localparam logic [(N+1)*M-1:0] LOG_PK = build_log();

    logic [M-1:0] exp_tab [0:N];
    logic [M-1:0] log_tab [0:N];

    for (genvar g = 0; g <= N; g++) begin : g_tab
        assign exp_tab[g] = EXP_PK[g*M +: M];
        assign log_tab[g] = LOG_PK[g*M +: M];
    end

    // log/antilog multiply; log of zero is all-ones
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a,
                                            input logic [M-1:0] b);
        logic [M-1:0] la;
        logic [M-1:0] lb;
        logic [M:0]   s;
        la = log_tab[a];
        lb = log_tab[b];
        s  = {1'b0, la} + {1'b0, lb};
        if (s >= (M+1)'(N)) s = s - (M+1)'(N);
        if (la == ONES || lb == ONES) return '0;
        return exp_tab[s[M-1:0]];
    endfunction

    typedef enum logic [2:0] {IDLE, LOAD, BM, CHIEN, OUT} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [M-1:0]  syn    [1:2*T];
    logic [M-1:0]  sig    [0:T];
    logic [M-1:0]  bpol   [0:T];
    logic [M-1:0]  gam;
    logic [LW-1:0] len;
    logic [M-1:0]  locbuf [0:T-1];
    logic [PW-1:0] wptr;

    logic [M-1:0]  d, ssel, csum, poly_in;
    logic [M-1:0]  sig_bm [0:T];
    logic [M-1:0]  bpol_bm[0:T];
    logic [M-1:0]  sig_ch [0:T];
    logic          upd, root, last_load, fail;

    assign poly_in   = (in_syndrome == ONES) ? '0 : exp_tab[in_syndrome];
    assign last_load = (state == LOAD) && in_valid
                       && (int'(cnt) == 2 * T - 1);

    always_comb begin
        d    = '0;
        ssel = '0;
        for (int j = 0; j <= T; j++) begin
            ssel = '0;
            for (int i = 1; i <= 2 * T; i++)
                if (int'(cnt) + 1 - j == i) ssel = syn[i];
            d = d ^ gf_mul(sig[j], ssel);
        end
        upd = (d != '0) && (2 * int'(len) <= int'(cnt));
        sig_bm[0]  = gf_mul(gam, sig[0]);
        bpol_bm[0] = upd ? sig[0] : '0;
        for (int j = 1; j <= T; j++) begin
            sig_bm[j]  = gf_mul(gam, sig[j]) ^ gf_mul(d, bpol[j-1]);
            bpol_bm[j] = upd ? sig[j] : bpol[j-1];
        end
        // sig doubles as the Chien term registers: scaling by a
        // nonzero constant keeps which coefficients are zero
        csum = '0;
        for (int j = 0; j <= T; j++) begin
            csum      = csum ^ sig[j];
            sig_ch[j] = gf_mul(sig[j], exp_tab[M'((N - j) % N)]);
        end
        root = (csum == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (in_valid) state_nx = LOAD;
            LOAD: begin
                if (!in_valid)                     state_nx = IDLE;
                else if (int'(cnt) == 2 * T - 1)   state_nx = BM;
            end
            BM:      if (int'(cnt) == 2 * T - 1) state_nx = CHIEN;
            CHIEN:   if (int'(cnt) == N - 1)     state_nx = OUT;
            OUT:     if (int'(cnt) == T - 1)     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            wptr <= '0;
            len  <= '0;
            gam  <= '0;
        end else begin
            unique case (state)
                IDLE, LOAD: begin
                    if (in_valid) begin
                        for (int i = 1; i <= 2 * T; i++)
                            if (int'(cnt) + 1 == i) syn[i] <= poly_in;
                        if (last_load) begin
                            cnt  <= '0;
                            len  <= '0;
                            gam  <= M'(1);
                            wptr <= '0;
                            for (int j = 0; j <= T; j++) begin
                                sig[j]  <= (j == 0) ? M'(1) : '0;
                                bpol[j] <= (j == 0) ? M'(1) : '0;
                            end
                            for (int i = 0; i < T; i++) locbuf[i] <= ONES;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        cnt <= '0;
                    end
                end
                BM: begin
                    sig  <= sig_bm;
                    bpol <= bpol_bm;
                    if (upd) begin
                        len <= LW'(int'(cnt) + 1 - int'(len));
                        gam <= d;
                    end
                    cnt <= (int'(cnt) == 2 * T - 1) ? '0 : cnt + 1'b1;
                end
                CHIEN: begin
                    sig <= sig_ch;
                    if (root) begin
                        for (int i = 0; i < T; i++)
                            if (int'(wptr) == i) locbuf[i] <= M'(cnt);
                        if (int'(wptr) < T) wptr <= wptr + 1'b1;
                    end
                    cnt <= (int'(cnt) == N - 1) ? '0 : cnt + 1'b1;
                end
                OUT:     cnt <= (int'(cnt) == T - 1) ? '0 : cnt + 1'b1;
                default: cnt <= '0;
            endcase
        end
    end

`ifdef BCH_FAIL_DETECT_EN
    localparam int RW = $clog2(N + 1);
    logic [RW-1:0] rcnt;
    int            deg;

    always_ff @(posedge clk) begin
        if (rst)                    rcnt <= '0;
        else if (last_load)         rcnt <= '0;
        else if (state == CHIEN && root) rcnt <= rcnt + 1'b1;
    end

    always_comb begin
        deg = 0;
        for (int j = 1; j <= T; j++)
            if (sig[j] != '0) deg = j;
        fail = (int'(rcnt) != int'(len)) || (deg != int'(len))
               || (int'(len) > T);
    end
`else
    assign fail = 1'b0;
`endif

    always_comb begin
        in_ready     = (state == IDLE) || (state == LOAD);
        out_valid    = (state == OUT);
        out_location = '0;
        out_fail     = 1'b0;
        if (state == OUT) begin
            out_location = ONES;
            for (int i = 0; i < T; i++)
                if (int'(cnt) == i) out_location = locbuf[i];
            if (fail) out_location = ONES;
            out_fail = fail;
        end
    end

endmodule

// File: tb/tb_bch_decoder_param.sv
// tb_bch_decoder_param: directed-vector bench for bch_decoder_param
// (M=4, T=3) with hand-computed locations, flags and latency.
module tb_bch_decoder_param;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_syndrome = 4'd0;
    logic       in_ready, out_valid, out_fail;
    logic [3:0] out_location;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef BCH_FAIL_DETECT_EN
    localparam logic EXP_BAD_FAIL = 1'b1;
`else
    localparam logic EXP_BAD_FAIL = 1'b0;
`endif

    bch_decoder_param #(.M(4), .T(3), .PRIM_POLY(5'b10011)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_syndrome  (in_syndrome),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_location (out_location),
        .out_fail     (out_fail)
    );

    always #5 clk = ~clk;

    // Drives one frame starting at the current negedge, optionally pulses
    // in_valid c cycles after the last word, and captures the results.
    task automatic run_frame(input logic [23:0] s, input int pulse_at,
                             output int lat, output logic [11:0] locs,
                             output logic [2:0] fails, output logic [2:0] vals,
                             output logic rdy_k1, output logic rdy_pulse,
                             output logic rdy_after, output logic ov_after,
                             output logic [3:0] loc_after);
        int c;
        locs = '0; fails = '0; vals = '0; rdy_pulse = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            in_valid    = 1'b1;
            in_syndrome = s[23-4*i -: 4];
        end
        @(negedge clk);
        in_valid = 1'b0; in_syndrome = 4'd0;
        c = 1;
        rdy_k1 = in_ready;
        while (out_valid !== 1'b1 && c < 60) begin
            in_valid = (c == pulse_at);
            if (c == pulse_at) rdy_pulse = in_ready;
            @(negedge clk);
            c++;
        end
        in_valid = 1'b0;
        lat = c;
        for (int t = 0; t < 3; t++) begin
            locs[11-4*t -: 4] = out_location;
            fails[2-t]        = out_fail;
            vals[2-t]         = out_valid;
            @(negedge clk);
        end
        rdy_after = in_ready;
        ov_after  = out_valid;
        loc_after = out_location;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        n_checks++;
        if (out_location !== 4'd0) begin
            n_fail++; $display("FAIL reset_out_location got %0d want 0", out_location);
        end
        n_checks++;
        if (out_fail !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_fail got %b want 0", out_fail);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_error();
        int lat; logic [11:0] locs; logic [2:0] fails, vals;
        logic rk1, rp, ra, ova; logic [3:0] la;
        run_frame(24'h5A05A0, -1, lat, locs, fails, vals, rk1, rp, ra, ova, la);
        n_checks++;
        if (lat !== 22) begin
            n_fail++; $display("FAIL single_latency got %0d want 22", lat);
        end
        n_checks++;
        if (locs !== 12'h5FF) begin
            n_fail++; $display("FAIL single_locs got %h want 5ff", locs);
        end
        n_checks++;
        if (fails !== 3'b000 || vals !== 3'b111) begin
            n_fail++; $display("FAIL single_flags got fail=%b valid=%b want 000/111", fails, vals);
        end
        n_checks++;
        if (rk1 !== 1'b0) begin
            n_fail++; $display("FAIL single_ready_low got %b want 0", rk1);
        end
        n_checks++;
        if (ra !== 1'b1 || ova !== 1'b0 || la !== 4'd0) begin
            n_fail++; $display("FAIL single_after got rdy=%b ov=%b loc=%0d want 1/0/0", ra, ova, la);
        end
    endtask

    task automatic test_two_errors();
        int lat; logic [11:0] locs; logic [2:0] fails, vals;
        logic rk1, rp, ra, ova; logic [3:0] la;
        run_frame(24'hC9F30F, -1, lat, locs, fails, vals, rk1, rp, ra, ova, la);
        n_checks++;
        if (locs !== 12'h27F) begin
            n_fail++; $display("FAIL double_locs got %h want 27f", locs);
        end
        n_checks++;
        if (fails !== 3'b000 || lat !== 22) begin
            n_fail++; $display("FAIL double_flags got fail=%b lat=%0d want 000/22", fails, lat);
        end
    endtask

    task automatic test_all_zero();
        int lat; logic [11:0] locs; logic [2:0] fails, vals;
        logic rk1, rp, ra, ova; logic [3:0] la;
        run_frame(24'hFFFFFF, -1, lat, locs, fails, vals, rk1, rp, ra, ova, la);
        n_checks++;
        if (locs !== 12'hFFF || fails !== 3'b000) begin
            n_fail++; $display("FAIL zero_result got locs=%h fail=%b want fff/000", locs, fails);
        end
        n_checks++;
        if (lat !== 22 || vals !== 3'b111) begin
            n_fail++; $display("FAIL zero_timing got lat=%0d valid=%b want 22/111", lat, vals);
        end
    endtask

    task automatic test_inconsistent();
        int lat; logic [11:0] locs; logic [2:0] fails, vals;
        logic rk1, rp, ra, ova; logic [3:0] la;
        run_frame(24'h0FFFFF, -1, lat, locs, fails, vals, rk1, rp, ra, ova, la);
        n_checks++;
        if (locs !== 12'hFFF) begin
            n_fail++; $display("FAIL bad_locs got %h want fff", locs);
        end
        n_checks++;
        if (fails !== {3{EXP_BAD_FAIL}}) begin
            n_fail++; $display("FAIL bad_fail got %b want %b", fails, {3{EXP_BAD_FAIL}});
        end
        n_checks++;
        if (ova !== 1'b0 || la !== 4'd0) begin
            n_fail++; $display("FAIL bad_after got ov=%b loc=%0d want 0/0", ova, la);
        end
    endtask

    task automatic test_drop();
        int lat; logic [11:0] locs; logic [2:0] fails, vals;
        logic rk1, rp, ra, ova; logic [3:0] la;
        logic [11:0] part;
        part = 12'h0C9;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            in_valid = 1'b1; in_syndrome = part[11-4*i -: 4];
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL drop_idle got rdy=%b ov=%b want 1/0", in_ready, out_valid);
        end
        run_frame(24'h5A05A0, -1, lat, locs, fails, vals, rk1, rp, ra, ova, la);
        n_checks++;
        if (locs !== 12'h5FF || lat !== 22) begin
            n_fail++; $display("FAIL drop_second got locs=%h lat=%0d want 5ff/22", locs, lat);
        end
    endtask

    task automatic test_chien_pulse();
        int lat; logic [11:0] locs; logic [2:0] fails, vals;
        logic rk1, rp, ra, ova; logic [3:0] la;
        run_frame(24'h5A05A0, 10, lat, locs, fails, vals, rk1, rp, ra, ova, la);
        n_checks++;
        if (rp !== 1'b0) begin
            n_fail++; $display("FAIL pulse_ready got %b want 0", rp);
        end
        n_checks++;
        if (locs !== 12'h5FF || lat !== 22 || vals !== 3'b111) begin
            n_fail++; $display("FAIL pulse_result got locs=%h lat=%0d valid=%b want 5ff/22/111", locs, lat, vals);
        end
    endtask

    task automatic test_reset_mid();
        logic [23:0] s;
        logic        seen;
        s = 24'hC9F30F;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            in_valid = 1'b1; in_syndrome = s[23-4*i -: 4];
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_ready got %b want 1", in_ready);
        end
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_no_output got %b want 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [11:0] locs; logic [2:0] fails, vals;
        logic rk1, rp, ra, ova; logic [3:0] la;
        logic [11:0] first;
        run_frame(24'hC9F30F, -1, lat, locs, fails, vals, rk1, rp, ra, ova, la);
        first = locs;
        run_frame(24'h5A05A0, -1, lat, locs, fails, vals, rk1, rp, ra, ova, la);
        n_checks++;
        if (first !== 12'h27F) begin
            n_fail++; $display("FAIL b2b_first got %h want 27f", first);
        end
        n_checks++;
        if (locs !== 12'h5FF || lat !== 22) begin
            n_fail++; $display("FAIL b2b_second got locs=%h lat=%0d want 5ff/22", locs, lat);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_error();
        test_two_errors();
        test_all_zero();
        test_inconsistent();
        test_drop();
        test_chien_pulse();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
